// File: rtl/sdram_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sdram_fifo_pkg
// Shared constants and helpers for the SDRAM read/write FIFO. The SDRAM
// controller imports the same package so both sides agree on word width and
// FIFO geometry.
//   FIFO_DATA_W        : FIFO word width (SDRAM bus word zero-extended)
//   FIFO_DEPTH         : storage words, power of two
//   FIFO_ADDR_W        : log2(FIFO_DEPTH)
//   FIFO_ALMOST_FULL   : almost_full asserts at count >= this value
//   FIFO_ALMOST_EMPTY  : almost_empty asserts at count <  this value
// -----------------------------------------------------------------------------
package sdram_fifo_pkg;

  localparam int FIFO_DATA_W       = 36;
  localparam int FIFO_DEPTH        = 16;
  localparam int FIFO_ADDR_W       = $clog2(FIFO_DEPTH);
  localparam int FIFO_ALMOST_FULL  = 12;
  localparam int FIFO_ALMOST_EMPTY = 4;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_flags_t;

  // All status flags are a pure function of the stored-word count.
  function automatic fifo_flags_t calc_flags(int unsigned count,
                                             int unsigned depth,
                                             int unsigned almost_full_val,
                                             int unsigned almost_empty_val);
    fifo_flags_t f;
    f.empty        = (count == 0);
    f.full         = (count == depth);
    f.almost_empty = (count <  almost_empty_val);
    f.almost_full  = (count >= almost_full_val);
    return f;
  endfunction

endpackage

// File: rtl/sdram_fifo_if.sv
// -----------------------------------------------------------------------------
// sdram_fifo_if
// FIFO data/handshake bundle.
//   master : drives wrreq, rdreq, data; observes q, usedw and status flags
//   slave  : the FIFO itself
// -----------------------------------------------------------------------------
interface sdram_fifo_if
  import sdram_fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
);

  logic              wrreq;
  logic              rdreq;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] q;
  logic [ADDR_W-1:0] usedw;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;

  modport master (
    output wrreq, rdreq, data,
    input  q, usedw, empty, full, almost_empty, almost_full
  );

  modport slave (
    input  wrreq, rdreq, data,
    output q, usedw, empty, full, almost_empty, almost_full
  );

endinterface

// File: rtl/sdram_fifo_ram.sv
// -----------------------------------------------------------------------------
// sdram_fifo_ram
// Simple dual-port RAM: one write port, one registered read port.
//   clock   : clock
//   we_i    : write enable;  waddr_i / wdata_i : write address / data
//   re_i    : read enable;   raddr_i           : read address
//   rdata_o : registered read data, held while re_i is low
// -----------------------------------------------------------------------------
module sdram_fifo_ram
  import sdram_fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto block RAM; validity of its
  // contents is tracked entirely by the pointers and count in the parent.
  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_fifo.sv
// -----------------------------------------------------------------------------
// sdram_fifo
// Single-clock FIFO in normal (non show-ahead) read mode: q presents the word
// one clock after an accepted rdreq. Writes while full and reads while empty
// are ignored. All flags and usedw are registered from the post-edge count.
//   clock : clock, all state updates on its rising edge
//   sclr  : synchronous active-high reset
//   bus   : sdram_fifo_if.slave (wrreq, rdreq, data, q, usedw, flags)
// -----------------------------------------------------------------------------
module sdram_fifo
  import sdram_fifo_pkg::*;
#(
  parameter int DATA_W           = FIFO_DATA_W,
  parameter int DEPTH            = FIFO_DEPTH,
  parameter int ALMOST_FULL_VAL  = FIFO_ALMOST_FULL,
  parameter int ALMOST_EMPTY_VAL = FIFO_ALMOST_EMPTY
) (
  input  logic         clock,
  input  logic         sclr,
  sdram_fifo_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE = 1;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  fifo_flags_t       flags_q, flags_d;
  // Low after reset until the first accepted read, forcing q to zero while the
  // unreset RAM output register still holds stale data.
  logic              q_live_q;
  logic [DATA_W-1:0] ram_rdata;
  logic              wr_ok, rd_ok;

  // Acceptance uses the registered flags, so a write while full is dropped
  // even when a read in the same cycle frees a slot.
  assign wr_ok = bus.wrreq & ~flags_q.full  & ~sclr;
  assign rd_ok = bus.rdreq & ~flags_q.empty & ~sclr;

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    flags_d = calc_flags(32'(count_d), DEPTH, ALMOST_FULL_VAL, ALMOST_EMPTY_VAL);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (sclr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flags_q  <= '{empty: 1'b1, full: 1'b0, almost_empty: 1'b1, almost_full: 1'b0};
      q_live_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
      if (rd_ok) q_live_q <= 1'b1;
    end
  end

  sdram_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock   (clock),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data),
    .re_i    (rd_ok),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  assign bus.q            = q_live_q ? ram_rdata : '0;
  assign bus.usedw        = count_q[ADDR_W-1:0];
  assign bus.empty        = flags_q.empty;
  assign bus.full         = flags_q.full;
  assign bus.almost_empty = flags_q.almost_empty;
  assign bus.almost_full  = flags_q.almost_full;

endmodule

// File: tb/tb_sdram_fifo.sv
// -----------------------------------------------------------------------------
// tb_sdram_fifo
// Directed stimulus with hand-computed expected words pushed into a scoreboard
// queue; a separate monitor pops and compares q one clock after each read that
// should be accepted. Flags and usedw are checked against constants.
// -----------------------------------------------------------------------------
module tb_sdram_fifo;

  logic clk  = 1'b0;
  logic sclr = 1'b1;

  always #5 clk = ~clk;

  sdram_fifo_if #(.DATA_W(36), .ADDR_W(4)) bus ();

  sdram_fifo dut (
    .clock (clk),
    .sclr  (sclr),
    .bus   (bus.slave)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [35:0] exp_q [$];
  bit          rd_expect = 1'b0;
  bit          fire;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: a read flagged as accepted at an edge is checked shortly after it.
  always @(posedge clk) begin
    fire = rd_expect;
    if (fire) begin
      #2;
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL q_order: got 0x%0h, expected nothing (scoreboard empty) at %0t",
                 bus.q, $time);
      end else begin
        check("q_order", {28'd0, bus.q}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  // One clock of stimulus; if exp_rd is set, the read is expected to return exp.
  task automatic tick(input bit wr, input bit rd, input logic [35:0] d,
                      input bit exp_rd, input logic [35:0] exp);
    bus.wrreq = wr;
    bus.rdreq = rd;
    bus.data  = d;
    rd_expect = exp_rd;
    if (exp_rd) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
    rd_expect = 1'b0;
  endtask

  task automatic check_status(input string tag, input int usedw, input bit empty,
                              input bit full, input bit ae, input bit af);
    check({tag, "_usedw"}, 64'(bus.usedw), 64'(usedw));
    check({tag, "_empty"}, 64'(bus.empty), 64'(empty));
    check({tag, "_full"},  64'(bus.full),  64'(full));
    check({tag, "_ae"},    64'(bus.almost_empty), 64'(ae));
    check({tag, "_af"},    64'(bus.almost_full),  64'(af));
  endtask

  initial begin
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
    bus.data  = '0;

    // Reset with both requests asserted: reset must win.
    sclr = 1'b1;
    tick(1'b1, 1'b1, 36'h123, 1'b0, '0);
    tick(1'b0, 1'b0, '0, 1'b0, '0);
    sclr = 1'b0;
    check_status("reset", 0, 1, 0, 1, 0);
    check("reset_q", {28'd0, bus.q}, 64'd0);

    // Basic: 9 writes 34..58 step 3, then 9 reads.
    for (int i = 0; i < 9; i++) tick(1'b1, 1'b0, 36'(34 + 3 * i), 1'b0, '0);
    check_status("basic_wr", 9, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      tick(1'b0, 1'b1, '0, 1'b1, 36'(34 + 3 * i));
      check("basic_rd_usedw", 64'(bus.usedw), 64'(8 - i));
    end
    check_status("basic_end", 0, 1, 0, 1, 0);

    // Fill: 19 writes of 1..19, only the first 16 are stored.
    for (int i = 1; i <= 19; i++) begin
      tick(1'b1, 1'b0, 36'(i), 1'b0, '0);
      if (i == 15) check_status("fill15", 15, 0, 0, 0, 1);
      if (i == 16) check_status("fill16", 0, 0, 1, 0, 1);
    end
    check_status("fill19", 0, 0, 1, 0, 1);
    for (int i = 1; i <= 16; i++) tick(1'b0, 1'b1, '0, 1'b1, 36'(i));
    check_status("fill_drained", 0, 1, 0, 1, 0);

    // Thresholds on the way up and back down.
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b0, 36'(100 + i), 1'b0, '0);
      if (i == 2)  check("thr_ae_at3",  64'(bus.almost_empty), 64'd1);
      if (i == 3)  check("thr_ae_at4",  64'(bus.almost_empty), 64'd0);
      if (i == 10) check("thr_af_at11", 64'(bus.almost_full),  64'd0);
      if (i == 11) check("thr_af_at12", 64'(bus.almost_full),  64'd1);
    end
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b1, '0, 1'b1, 36'(100 + i));
      if (i == 0) check("thr_af_at11_dn", 64'(bus.almost_full),  64'd0);
      if (i == 7) check("thr_ae_at4_dn",  64'(bus.almost_empty), 64'd0);
      if (i == 8) check("thr_ae_at3_dn",  64'(bus.almost_empty), 64'd1);
    end

    // Simultaneous read/write at count 5.
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 36'(200 + i), 1'b0, '0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b1, 36'(205 + i), 1'b1, 36'(200 + i));
      check("rdwr_usedw", 64'(bus.usedw), 64'd5);
    end
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, '0, 1'b1, 36'(210 + i));

    // At full, read+write: the write is dropped, count becomes 15.
    for (int i = 0; i < 16; i++) tick(1'b1, 1'b0, 36'(300 + i), 1'b0, '0);
    tick(1'b1, 1'b1, 36'd999, 1'b1, 36'd300);
    check_status("full_rdwr", 15, 0, 0, 0, 1);
    for (int i = 1; i < 16; i++) tick(1'b0, 1'b1, '0, 1'b1, 36'(300 + i));
    check_status("full_rdwr_drained", 0, 1, 0, 1, 0);

    // Underflow: reads while empty leave q at the last word read (315).
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, '0, 1'b0, '0);
    check("underflow_q", {28'd0, bus.q}, 64'd315);
    check_status("underflow", 0, 1, 0, 1, 0);

    // Mid-operation reset at count 7, with both requests asserted.
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b0, 36'(400 + i), 1'b0, '0);
    check("midrst_pre_usedw", 64'(bus.usedw), 64'd7);
    sclr = 1'b1;
    tick(1'b1, 1'b1, 36'h555, 1'b0, '0);
    sclr = 1'b0;
    check_status("midrst", 0, 1, 0, 1, 0);
    check("midrst_q", {28'd0, bus.q}, 64'd0);
    tick(1'b1, 1'b0, 36'hABC, 1'b0, '0);
    check("midrst_wr_usedw", 64'(bus.usedw), 64'd1);
    tick(1'b0, 1'b1, '0, 1'b1, 36'hABC);
    check_status("midrst_end", 0, 1, 0, 1, 0);

    repeat (3) @(posedge clk);
    #3;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sdram_fifo.md
SDRAM_FIFO -- requirements
Module: sdram_fifo

Interface
REQ-001 Parameter DATA_W, default 36, word width of data and q.
REQ-002 Parameter DEPTH, default 16, storage words (power of two); ADDR_W = log2(DEPTH) = 4.
REQ-003 Parameter ALMOST_FULL_VAL, default 12, almost_full threshold in words.
REQ-004 Parameter ALMOST_EMPTY_VAL, default 4, almost_empty threshold in words.
REQ-005 clock  input  1  single clock; every register updates on its rising edge.
REQ-006 sclr  input  1  reset; synchronous, active-high.
REQ-007 wrreq  input  1  write request.
REQ-008 rdreq  input  1  read request.
REQ-009 data  input  DATA_W  write data; SDRAM bus word zero-extended into 36 bits.
REQ-010 q  output  DATA_W  read data.
REQ-011 usedw  output  ADDR_W  stored word count, modulo DEPTH.
REQ-012 empty  output  1  high when 0 words are stored.
REQ-013 full  output  1  high when DEPTH words are stored.
REQ-014 almost_empty  output  1  high when stored count < ALMOST_EMPTY_VAL.
REQ-015 almost_full  output  1  high when stored count >= ALMOST_FULL_VAL.

Function
REQ-016 Internal count is ADDR_W+1 bits wide (0..DEPTH); usedw = count[ADDR_W-1:0], so it reads 0 when full.
REQ-017 Write acceptance: a write is accepted when wrreq=1 and full=0; data is stored at the write pointer, which then increments and wraps modulo DEPTH.
REQ-018 Write while full: wrreq with full=1 is ignored; no pointer, count or contents change, even if rdreq is also high.
REQ-019 Read acceptance: a read is accepted when rdreq=1 and empty=0; the word at the read pointer is registered onto q, and the read pointer increments and wraps modulo DEPTH.
REQ-020 Read mode is normal (not show-ahead): q presents the word one clock after the accepted rdreq edge.
REQ-021 Read while empty: rdreq with empty=1 is ignored; q holds its last value.
REQ-022 q holds its value in every cycle without an accepted read.
REQ-023 Simultaneous accepted read and write: count is unchanged; the read returns the oldest word; a write into an empty FIFO is not readable in the same cycle.
REQ-024 Count changes by +1 for a write only, -1 for a read only, and 0 for both or neither.
REQ-025 All flags and usedw are registered, derived from the post-edge count, and valid in the same cycle as the count.
REQ-026 Words are returned in exact write order with no loss or duplication.

Reset
REQ-027 While sclr=1 at a clock edge: read and write pointers = 0, count = 0, q = 0.
REQ-028 Output values during reset: empty=1, almost_empty=1, full=0, almost_full=0, usedw=0.
REQ-029 sclr overrides simultaneous rdreq and wrreq; stored contents are discarded logically, and the RAM array itself need not be cleared.
REQ-030 Mid-operation reset: the first write after sclr deasserts is the first word read out.

Structure
REQ-031 A shared package holds DATA_W, DEPTH, ADDR_W and the threshold defaults, and is also used by the SDRAM controller.
REQ-032 Storage is one sub-module, sdram_fifo_ram: simple dual-port RAM, one write port, one registered read port, no reset.
REQ-033 Pointers, count, flags and the q register live in sdram_fifo.

Verification
REQ-034 Reset, then 9 writes (34, 37, ..., 58), then 9 reads: q sequence 34..58 step 3, each one cycle after its rdreq edge; usedw 9 -> 0; empty=1 at end.
REQ-035 Fill: 19 consecutive writes (values 1..19): first 16 stored; full=1 and usedw=0 after the 16th; values 17..19 dropped; 16 reads return 1..16.
REQ-036 Thresholds: almost_empty falls when count reaches 4; almost_full rises when count reaches 12; both flags release on the way back down.
REQ-037 Simultaneous rd/wr at count=5 for 10 cycles: usedw stays 5; data order is preserved. At full, rd+wr: write dropped, count becomes 15.
REQ-038 Underflow: rdreq for 3 cycles while empty: q unchanged, usedw=0, empty stays 1.
REQ-039 Mid-operation reset at count=7: next cycle empty=1, usedw=0, q=0; a subsequent write of 0xABC followed by a read returns 0xABC.
